// File: rtl/wasca_switch_scanner_if.sv
// Avalon-MM slave bus bundle for the switch scanner: register select,
// write strobe/data and the registered read data path.
interface wasca_switch_scanner_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/wasca_switch_scanner.sv
// Switch debounce and event controller. Raw switch lines are synchronised,
// debounced on a periodic sample tick, and qualified rising/falling edges are
// latched into a write-1-to-clear capture register that drives a maskable
// level interrupt. Register map: 0 state, 1 irq mask, 2 edge capture,
// 3 edge enable (7:0 rising, 15:8 falling).
module wasca_switch_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  wasca_switch_scanner_if.slave bus,
  input  logic [7:0]            in_port,
  output logic                  irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Priming sequence: wait for one tick to fill the sample history, then the
  // next tick loads state directly so held switches never look like edges.
  typedef enum logic [1:0] {
    PRIME_IDLE,
    PRIME_ARMED,
    PRIME_RUN
  } primeState_t;

  primeState_t primeState_q, primeState_d;

  logic [7:0]      sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            loadAll;
  logic            primed;

  logic [7:0]  lastSample_q, lastSample_d;
  logic [7:0]  state_q, state_d;
  logic [7:0]  edgeHit_q, edgeHit_d;
  logic [7:0]  capture_q, capture_d;
  logic [7:0]  mask_q, mask_d;
  logic [15:0] edgeEn_q, edgeEn_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q, irq_d;

  logic        wrEn;
  logic [7:0]  stable;
  logic [7:0]  rise, fall;
  logic [15:0] unusedWriteBits;

  assign tick    = (cnt_q == CntMax);
  assign primed  = (primeState_q == PRIME_RUN);
  assign wrEn    = bus.chipselect && !bus.write_n;
  assign unusedWriteBits = bus.writedata[31:16];

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

  // Two-flop synchroniser on the asynchronous switch pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Free-running sample-tick counter, wraps after DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Priming FSM next-state logic; loadAll marks the tick that seeds state.
  always_comb begin
    primeState_d = primeState_q;
    loadAll      = 1'b0;
    case (primeState_q)
      PRIME_IDLE: begin
        if (tick) primeState_d = PRIME_ARMED;
      end
      PRIME_ARMED: begin
        if (tick) begin
          primeState_d = PRIME_RUN;
          loadAll      = 1'b1;
        end
      end
      PRIME_RUN: begin
        primeState_d = PRIME_RUN;
      end
      default: begin
        primeState_d = PRIME_IDLE;
      end
    endcase
  end

  // Debounce: a bit is accepted once two consecutive ticks agree; edges are
  // only reported once primed and only for enabled directions.
  always_comb begin
    lastSample_d = lastSample_q;
    state_d      = state_q;
    stable       = ~(sync2_q ^ lastSample_q);
    if (tick) begin
      lastSample_d = sync2_q;
      if (loadAll) begin
        state_d = sync2_q;
      end else begin
        state_d = (state_q & ~stable) | (sync2_q & stable);
      end
    end
    rise      = ~state_q & state_d & edgeEn_q[7:0];
    fall      = state_q & ~state_d & edgeEn_q[15:8];
    edgeHit_d = primed ? (rise | fall) : 8'h00;
  end

  // Register writes; a new edge overrides a same-cycle write-1-to-clear.
  always_comb begin
    capture_d = capture_q;
    mask_d    = mask_q;
    edgeEn_d  = edgeEn_q;
    if (wrEn) begin
      case (bus.address)
        2'd1:    mask_d    = bus.writedata[7:0];
        2'd2:    capture_d = capture_q & ~bus.writedata[7:0];
        2'd3:    edgeEn_d  = bus.writedata[15:0];
        default: ;
      endcase
    end
    capture_d = capture_d | edgeHit_q;
    irq_d     = |(capture_q & mask_q);
  end

  // Read mux, registered every cycle without a read strobe.
  always_comb begin
    readdata_d = 32'h0;
    case (bus.address)
      2'd0:    readdata_d = {24'h0, state_q};
      2'd1:    readdata_d = {24'h0, mask_q};
      2'd2:    readdata_d = {24'h0, capture_q};
      2'd3:    readdata_d = {16'h0, edgeEn_q};
      default: readdata_d = 32'h0;
    endcase
  end

  // State registers for the debounce, capture and bus-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      primeState_q <= PRIME_IDLE;
      cnt_q        <= '0;
      lastSample_q <= '0;
      state_q      <= '0;
      edgeHit_q    <= '0;
      capture_q    <= '0;
      mask_q       <= '0;
      edgeEn_q     <= 16'h00FF;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      primeState_q <= primeState_d;
      cnt_q        <= cnt_d;
      lastSample_q <= lastSample_d;
      state_q      <= state_d;
      edgeHit_q    <= edgeHit_d;
      capture_q    <= capture_d;
      mask_q       <= mask_d;
      edgeEn_q     <= edgeEn_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_wasca_switch_scanner.sv
// Directed testbench for the switch scanner with a short tick period so that
// debounce, edge capture, interrupt and reset behaviour fit in a few cycles.
module tb_wasca_switch_scanner;

  localparam int unsigned DebounceCycles = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inPort;
  logic       irq;

  int compared   = 0;
  int mismatched = 0;

  wasca_switch_scanner_if busIf ();

  wasca_switch_scanner #(
    .DEBOUNCE_CYCLES(DebounceCycles)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (busIf),
    .in_port (inPort),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    busIf.address    = addr;
    busIf.writedata  = data;
    busIf.chipselect = 1'b1;
    busIf.write_n    = 1'b0;
    step(1);
    busIf.chipselect = 1'b0;
    busIf.write_n    = 1'b1;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    busIf.address = addr;
    step(1);
    data = busIf.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset            = 1'b1;
    inPort           = 8'hA5;
    busIf.address    = 2'd0;
    busIf.chipselect = 1'b0;
    busIf.write_n    = 1'b1;
    busIf.writedata  = 32'h0;
    step(3);
    compared++;
    if (busIf.readdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_readdata: got %h expected %h", busIf.readdata, 32'h0);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    reset = 1'b0;
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_00A5) begin
      mismatched++;
      $display("[TB] FAIL prime_state: got %h expected %h", d, 32'h0000_00A5);
    end
    busRead(2'd1, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mask: got %h expected %h", d, 32'h0);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL prime_capture: got %h expected %h", d, 32'h0);
    end
    busRead(2'd3, d);
    compared++;
    if (d !== 32'h0000_00FF) begin
      mismatched++;
      $display("[TB] FAIL reset_edge_en: got %h expected %h", d, 32'h0000_00FF);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL prime_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    int          lat;
    logic        found;
    inPort = 8'hA4;
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_00A4) begin
      mismatched++;
      $display("[TB] FAIL fall_disabled_state: got %h expected %h", d, 32'h0000_00A4);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL fall_disabled_capture: got %h expected %h", d, 32'h0);
    end
    busWrite(2'd1, 32'h0000_0001);
    busIf.address = 2'd0;
    inPort = 8'hA5;
    found  = 1'b0;
    lat    = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (busIf.readdata[0] === 1'b1) begin
        found = 1'b1;
        lat   = k;
        compared++;
        if (irq !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL rise_irq_early: got %b expected 0", irq);
        end
        step(1);
        compared++;
        if (irq !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL rise_irq_t2: got %b expected 1", irq);
        end
        break;
      end
    end
    compared++;
    if (found !== 1'b1 || lat > 11) begin
      mismatched++;
      $display("[TB] FAIL rise_latency: got found=%b cycles=%0d expected found=1 cycles<=11", found, lat);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0000_0001) begin
      mismatched++;
      $display("[TB] FAIL rise_capture: got %h expected %h", d, 32'h0000_0001);
    end
    busWrite(2'd2, 32'h0000_0001);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL w1c_irq_t1: got %b expected 1", irq);
    end
    step(1);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL w1c_irq_t2: got %b expected 0", irq);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL w1c_capture: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    busWrite(2'd1, 32'h0000_00FF);
    inPort = 8'hAD;
    step(2);
    inPort = 8'hA5;
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_00A5) begin
      mismatched++;
      $display("[TB] FAIL glitch_state: got %h expected %h", d, 32'h0000_00A5);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL glitch_capture: got %h expected %h", d, 32'h0);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL glitch_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_fall_only();
    logic [31:0] d;
    busWrite(2'd3, 32'h0000_FF00);
    inPort = 8'h25;
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_0025) begin
      mismatched++;
      $display("[TB] FAIL fall_state: got %h expected %h", d, 32'h0000_0025);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0000_0080) begin
      mismatched++;
      $display("[TB] FAIL fall_capture: got %h expected %h", d, 32'h0000_0080);
    end
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL fall_irq: got %b expected 1", irq);
    end
    busWrite(2'd2, 32'h0000_00FF);
    step(1);
    inPort = 8'hA5;
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_00A5) begin
      mismatched++;
      $display("[TB] FAIL rise_masked_state: got %h expected %h", d, 32'h0000_00A5);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rise_disabled_capture: got %h expected %h", d, 32'h0);
    end
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rise_disabled_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_set_clear_same_cycle();
    logic [31:0] d;
    int          sawSet;
    inPort           = 8'hA1;
    busIf.address    = 2'd2;
    busIf.writedata  = 32'h0000_0004;
    busIf.chipselect = 1'b1;
    busIf.write_n    = 1'b0;
    sawSet = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (busIf.readdata === 32'h0000_0004) sawSet++;
    end
    busIf.chipselect = 1'b0;
    busIf.write_n    = 1'b1;
    compared++;
    if (sawSet !== 1) begin
      mismatched++;
      $display("[TB] FAIL set_wins_cycles: got %0d expected 1", sawSet);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL set_wins_after_clear: got %h expected %h", d, 32'h0);
    end
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_00A1) begin
      mismatched++;
      $display("[TB] FAIL set_wins_state: got %h expected %h", d, 32'h0000_00A1);
    end
  endtask

  task automatic test_mask_and_reset();
    logic [31:0] d;
    busWrite(2'd3, 32'h0000_FFFF);
    inPort = 8'h5E;
    step(14);
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0000_00FF) begin
      mismatched++;
      $display("[TB] FAIL all_capture: got %h expected %h", d, 32'h0000_00FF);
    end
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL all_irq: got %b expected 1", irq);
    end
    busWrite(2'd1, 32'h0000_0000);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mask_off_t1: got %b expected 1", irq);
    end
    step(1);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mask_off_t2: got %b expected 0", irq);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0000_00FF) begin
      mismatched++;
      $display("[TB] FAIL masked_retained: got %h expected %h", d, 32'h0000_00FF);
    end
    busWrite(2'd1, 32'hFFFF_FFFF);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mask_on_t1: got %b expected 0", irq);
    end
    step(1);
    compared++;
    if (irq !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mask_on_t2: got %b expected 1", irq);
    end
    busIf.address = 2'd2;
    reset = 1'b1;
    step(1);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset_irq: got %b expected 0", irq);
    end
    compared++;
    if (busIf.readdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_readdata: got %h expected %h", busIf.readdata, 32'h0);
    end
    reset = 1'b0;
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_state: got %h expected %h", d, 32'h0);
    end
    busRead(2'd1, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_mask: got %h expected %h", d, 32'h0);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_capture: got %h expected %h", d, 32'h0);
    end
    busRead(2'd3, d);
    compared++;
    if (d !== 32'h0000_00FF) begin
      mismatched++;
      $display("[TB] FAIL midreset_edge_en: got %h expected %h", d, 32'h0000_00FF);
    end
    step(14);
    busRead(2'd0, d);
    compared++;
    if (d !== 32'h0000_005E) begin
      mismatched++;
      $display("[TB] FAIL reprime_state: got %h expected %h", d, 32'h0000_005E);
    end
    busRead(2'd2, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reprime_capture: got %h expected %h", d, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_glitch();
    test_fall_only();
    test_set_clear_same_cycle();
    test_mask_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
